// File: rtl/pc_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_unit_pkg
//  Description : Shared types and constants for the program-counter unit.
//                - pc_state_t   : sequencer states (BOOT, RUN, HALT)
//                - redirect_t   : which redirect source won target selection
//                - INSTR_BYTES  : size of one instruction (sequential step)
//  Revision    : 1.0 - initial release
// ============================================================================
package pc_unit_pkg;

    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

    typedef enum logic [1:0] {
        RED_NONE   = 2'd0,
        RED_BRANCH = 2'd1,
        RED_JAL    = 2'd2,
        RED_JALR   = 2'd3
    } redirect_t;

endpackage : pc_unit_pkg
`default_nettype wire

// File: rtl/pc_target_sel.sv
`default_nettype none
// ============================================================================
//  Module      : pc_target_sel
//  Description : Combinational redirect-target selection.
//                Priority JumpReg > Jump > BranchTaken. JALR clears bit 0.
//                Build option PC_MISALIGN_TRAP_EN:
//                  defined   - target passed through, misaligned flag live
//                  undefined - target bits [1:0] forced to 00, flag always 0
//  Ports       : branch_taken, jump, jump_reg - redirect requests
//                alu_result     - ALU-computed target
//                redirect_valid - some redirect request is active
//                target         - selected (and possibly aligned) target
//                misaligned     - target bits [1:0] are non-zero
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_target_sel
    import pc_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            branch_taken,
    input  logic            jump,
    input  logic            jump_reg,
    input  logic [XLEN-1:0] alu_result,
    output logic            redirect_valid,
    output logic [XLEN-1:0] target,
    output logic            misaligned
);

    localparam logic [XLEN-1:0] c_jalr_mask  = ~XLEN'(1);
    localparam logic [XLEN-1:0] c_align_mask = ~XLEN'(3);

    redirect_t       w_sel;
    logic [XLEN-1:0] w_raw;

    always_comb begin
        w_sel = RED_NONE;
        if (jump_reg) begin
            w_sel = RED_JALR;
        end else if (jump) begin
            w_sel = RED_JAL;
        end else if (branch_taken) begin
            w_sel = RED_BRANCH;
        end
    end

    assign w_raw          = (w_sel == RED_JALR) ? (alu_result & c_jalr_mask) : alu_result;
    assign redirect_valid = (w_sel != RED_NONE);

`ifdef PC_MISALIGN_TRAP_EN
    assign target = w_raw;
`else
    // Without trapping, silently realign so the PC can never go misaligned.
    assign target = w_raw & c_align_mask;
`endif

    assign misaligned = (target[1:0] != 2'b00);

endmodule : pc_target_sel
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_unit
//  Description : Program-counter producer for the single-cycle RISC-V
//                datapath. Holds the PC, sequences BOOT -> RUN, honours
//                stalls and buffers a redirect that arrives during a stall
//                (latest wins, a live redirect beats a buffered one).
//                Build option PC_MISALIGN_TRAP_EN: a misaligned target at
//                the moment it is applied moves the unit to HALT with a
//                sticky Trap and TrapPc; otherwise Trap/TrapPc stay 0.
//  Ports       : clk, rst_n (async, active-low)
//                Stall, BranchTaken, Jump, JumpReg, AluResult - control in
//                Pc, PcPlus4, PcValid, Trap, TrapPc            - outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int                XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            Stall,
    input  logic            BranchTaken,
    input  logic            Jump,
    input  logic            JumpReg,
    input  logic [XLEN-1:0] AluResult,
    output logic [XLEN-1:0] Pc,
    output logic [XLEN-1:0] PcPlus4,
    output logic            PcValid,
    output logic            Trap,
    output logic [XLEN-1:0] TrapPc
);

`ifdef PC_MISALIGN_TRAP_EN
    localparam bit c_trap_en = 1'b1;
`else
    localparam bit c_trap_en = 1'b0;
`endif

    pc_state_t       r_state,    w_state_nxt;
    logic [XLEN-1:0] r_pc,       w_pc_nxt;
    logic            r_pend_vld, w_pend_vld_nxt;
    logic [XLEN-1:0] r_pend_tgt, w_pend_tgt_nxt;
    logic            r_trap,     w_trap_nxt;
    logic [XLEN-1:0] r_trap_pc,  w_trap_pc_nxt;

    logic            w_red_vld;
    logic [XLEN-1:0] w_sel_tgt;
    logic            w_sel_mis;
    logic [XLEN-1:0] w_apply_tgt;
    logic            w_apply_mis;

    pc_target_sel #(
        .XLEN (XLEN)
    ) u_target_sel (
        .branch_taken   (BranchTaken),
        .jump           (Jump),
        .jump_reg       (JumpReg),
        .alu_result     (AluResult),
        .redirect_valid (w_red_vld),
        .target         (w_sel_tgt),
        .misaligned     (w_sel_mis)
    );

    // Target that would be loaded on an unstalled edge: live redirect first,
    // otherwise the buffered one. Alignment is judged only here, so a
    // misaligned target sitting in the buffer does not trap until applied.
    assign w_apply_tgt = w_red_vld ? w_sel_tgt : r_pend_tgt;
    assign w_apply_mis = w_red_vld ? w_sel_mis : (r_pend_tgt[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= BOOT;
            r_pc       <= RESET_VECTOR;
            r_pend_vld <= 1'b0;
            r_pend_tgt <= '0;
            r_trap     <= 1'b0;
            r_trap_pc  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_pend_vld <= w_pend_vld_nxt;
            r_pend_tgt <= w_pend_tgt_nxt;
            r_trap     <= w_trap_nxt;
            r_trap_pc  <= w_trap_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_pend_vld_nxt = r_pend_vld;
        w_pend_tgt_nxt = r_pend_tgt;
        w_trap_nxt     = r_trap;
        w_trap_pc_nxt  = r_trap_pc;

        case (r_state)
            BOOT: begin
                // PC already holds RESET_VECTOR; just start fetching.
                w_state_nxt = RUN;
            end
            RUN: begin
                if (Stall) begin
                    if (w_red_vld) begin
                        w_pend_vld_nxt = 1'b1;
                        w_pend_tgt_nxt = w_sel_tgt;
                    end
                end else if (w_red_vld || r_pend_vld) begin
                    w_pend_vld_nxt = 1'b0;
                    if (c_trap_en && w_apply_mis) begin
                        w_state_nxt   = HALT;
                        w_trap_nxt    = 1'b1;
                        w_trap_pc_nxt = w_apply_tgt;
                    end else begin
                        w_pc_nxt = w_apply_tgt;
                    end
                end else begin
                    w_pc_nxt = PcPlus4;
                end
            end
            HALT: begin
                // Frozen until reset.
            end
            default: begin
                w_state_nxt = BOOT;
            end
        endcase
    end

    assign Pc      = r_pc;
    assign PcPlus4 = r_pc + XLEN'(INSTR_BYTES);
    assign PcValid = (r_state == RUN);
    assign Trap    = r_trap;
    assign TrapPc  = r_trap_pc;

endmodule : pc_unit
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_unit
//  Description : Self-checking bench for pc_unit. Directed scenarios plus a
//                randomized run, all compared against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

`ifdef PC_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        Stall;
    logic        BranchTaken;
    logic        Jump;
    logic        JumpReg;
    logic [31:0] AluResult;
    logic [31:0] Pc;
    logic [31:0] PcPlus4;
    logic        PcValid;
    logic        Trap;
    logic [31:0] TrapPc;

    pc_unit #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Stall       (Stall),
        .BranchTaken (BranchTaken),
        .Jump        (Jump),
        .JumpReg     (JumpReg),
        .AluResult   (AluResult),
        .Pc          (Pc),
        .PcPlus4     (PcPlus4),
        .PcValid     (PcValid),
        .Trap        (Trap),
        .TrapPc      (TrapPc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: mode is "boot", "run" or "halt".
    string       m_mode;
    logic [31:0] m_pc;
    logic        m_trap;
    logic [31:0] m_trap_pc;
    logic [31:0] m_pend[$];

    task automatic model_reset();
        m_mode    = "boot";
        m_pc      = 32'h0000_0000;
        m_trap    = 1'b0;
        m_trap_pc = 32'h0;
        m_pend.delete();
    endtask

    task automatic model_edge(input bit s, input bit b, input bit j, input bit jr,
                              input logic [31:0] a);
        bit          has_red;
        logic [31:0] tgt;
        logic [31:0] t;
        has_red = b || j || jr;
        tgt = a;
        if (jr) tgt = a - (a % 2);
        if (!TRAP_EN) tgt = tgt - (tgt % 4);
        if (m_mode == "boot") begin
            m_mode = "run";
        end else if (m_mode == "run") begin
            if (s) begin
                if (has_red) begin
                    m_pend.delete();
                    m_pend.push_back(tgt);
                end
            end else if (has_red || m_pend.size() > 0) begin
                t = has_red ? tgt : m_pend[0];
                m_pend.delete();
                if (TRAP_EN && (t % 4) != 0) begin
                    m_mode    = "halt";
                    m_trap    = 1'b1;
                    m_trap_pc = t;
                end else begin
                    m_pc = t;
                end
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, " Pc"},      Pc,              m_pc);
        check({tag, " PcPlus4"}, PcPlus4,         m_pc + 32'd4);
        check({tag, " PcValid"}, {31'd0, PcValid}, {31'd0, (m_mode == "run")});
        check({tag, " Trap"},    {31'd0, Trap},    {31'd0, m_trap});
        check({tag, " TrapPc"},  TrapPc,          m_trap_pc);
    endtask

    // One clock: drive inputs, update model at the edge, check 1 time unit later.
    task automatic cycle(input string tag, input bit s, input bit b, input bit j,
                         input bit jr, input logic [31:0] a);
        Stall = s; BranchTaken = b; Jump = j; JumpReg = jr; AluResult = a;
        @(posedge clk);
        model_edge(s, b, j, jr, a);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] a;
        rst_n = 1'b0; Stall = 1'b0; BranchTaken = 1'b0; Jump = 1'b0; JumpReg = 1'b0;
        AluResult = 32'h0;
        model_reset();

        // 1. Reset and sequential fetch
        #2;
        check_all("in reset");
        do_reset();
        cycle("t1 boot", 0, 0, 0, 0, 32'h0);
        check("t1 pc0", Pc, 32'h0);
        cycle("t1 seq", 0, 0, 0, 0, 32'h0);
        check("t1 pc4", Pc, 32'h4);
        cycle("t1 seq", 0, 0, 0, 0, 32'h0);
        check("t1 pc8", Pc, 32'h8);

        // 2. JAL and JALR
        cycle("t2 jal", 0, 0, 1, 0, 32'h100);
        check("t2 jal pc", Pc, 32'h100);
        cycle("t2 seq", 0, 0, 0, 0, 32'h0);
        check("t2 pc104", Pc, 32'h104);
        cycle("t2 jalr", 0, 0, 0, 1, 32'h201);
        check("t2 jalr pc", Pc, 32'h200);
        // priority: JumpReg over Jump over BranchTaken
        cycle("t2 prio", 0, 1, 1, 1, 32'h301);
        check("t2 prio pc", Pc, 32'h300);

        // 3. Branch captured during stall
        cycle("t3 stall br", 1, 1, 0, 0, 32'h40);
        check("t3 hold", Pc, 32'h300);
        cycle("t3 stall", 1, 0, 0, 0, 32'h0);
        cycle("t3 stall", 1, 0, 0, 0, 32'h0);
        cycle("t3 release", 0, 0, 0, 0, 32'h0);
        check("t3 pc40", Pc, 32'h40);
        // latest pending wins; a live redirect beats the pending one
        cycle("t3 st a", 1, 1, 0, 0, 32'h80);
        cycle("t3 st b", 1, 0, 1, 0, 32'h90);
        cycle("t3 rel", 0, 0, 0, 0, 32'h0);
        check("t3 latest", Pc, 32'h90);
        cycle("t3 st c", 1, 1, 0, 0, 32'hA0);
        cycle("t3 live", 0, 0, 1, 0, 32'hB0);
        check("t3 live wins", Pc, 32'hB0);
        cycle("t3 after", 0, 0, 0, 0, 32'h0);
        check("t3 no pend", Pc, 32'hB4);

        // 4. Wrap-around
        cycle("t4 jump", 0, 0, 1, 0, 32'hFFFF_FFFC);
        check("t4 plus4", PcPlus4, 32'h0);
        cycle("t4 wrap", 0, 0, 0, 0, 32'h0);
        check("t4 pc0", Pc, 32'h0);

        // 6. Asynchronous reset mid-stall with a pending redirect
        cycle("t6 stall br", 1, 1, 0, 0, 32'h300);
        cycle("t6 stall", 1, 0, 0, 0, 32'h0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("t6 async");
        check("t6 pc", Pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle("t6 boot", 0, 0, 0, 0, 32'h0);
        cycle("t6 seq", 0, 0, 0, 0, 32'h0);
        check("t6 pend gone", Pc, 32'h4);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            a = $urandom;
            if (TRAP_EN) a = a & 32'hFFFF_FFFC;
            if ($urandom_range(0, 19) == 0) a = 32'hFFFF_FFF0 | (a & 32'hF);
            cycle("rand", ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 7) == 0), a);
        end

        // 5. Misaligned JAL target
        do_reset();
        cycle("t5 boot", 0, 0, 0, 0, 32'h0);
        cycle("t5 seq", 0, 0, 0, 0, 32'h0);
        cycle("t5 jal", 0, 0, 1, 0, 32'h102);
        if (TRAP_EN) begin
            check("t5 trappc", TrapPc, 32'h102);
            check("t5 frozen", Pc, 32'h4);
        end else begin
            check("t5 forced", Pc, 32'h100);
            check("t5 notrap", {31'd0, Trap}, 32'd0);
        end
        cycle("t5 after", 0, 0, 1, 0, 32'h400);
        cycle("t5 after", 1, 1, 0, 0, 32'h500);
        cycle("t5 after", 0, 0, 0, 0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pc_unit
`default_nettype wire

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Program-counter producer for the single-cycle RISC-V datapath.
- Holds the architectural PC that feeds the ALU operand-A mux, PC-relative address generation and the instruction fetch address.
- Consumes the ALU result as the redirect target for JAL/JALR/branch, closing the loop from the ALU back to the PC.
- Adds stall handling, buffering of a redirect received during a stall, and boot sequencing.

Parameters:
- XLEN, 32, datapath and PC width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset. Must be 4-byte aligned.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- Stall  input  1  hold the PC this cycle.
- BranchTaken  input  1  conditional branch resolved taken; target is AluResult.
- Jump  input  1  JAL; target is AluResult.
- JumpReg  input  1  JALR; target is AluResult with bit 0 cleared.
- AluResult  input  XLEN  redirect target computed by the ALU.
- Pc  output  XLEN  current PC.
- PcPlus4  output  XLEN  Pc + 4 modulo 2^XLEN, combinational from Pc.
- PcValid  output  1  Pc holds a fetchable address.
- Trap  output  1  misaligned-target trap, sticky.
- TrapPc  output  XLEN  target address that caused the trap.

Behaviour:
Reset
- Async assert forces, immediately: state=BOOT, Pc=RESET_VECTOR, PcPlus4=RESET_VECTOR+4, PcValid=0, Trap=0, TrapPc=0, pending redirect cleared.
- This applies from any state, including mid-stall with a pending redirect.

States
- BOOT:
  - Pc=RESET_VECTOR, PcValid=0.
  - Next edge goes to RUN, independent of Stall.
  - Redirect inputs are ignored in BOOT.
- RUN: PcValid=1. Per rising edge, in priority order:
  1. Stall=1 with any redirect input high: capture the target into the pending register; Pc holds. A newer redirect overwrites the pending one (latest wins).
  2. Stall=1, no redirect: Pc holds; any pending redirect is kept.
  3. Stall=0 with a redirect input high: Pc <= new target; pending is cleared. A live redirect beats a pending one.
  4. Stall=0, pending valid, no redirect: Pc <= pending target; pending is cleared.
  5. Otherwise: Pc <= PcPlus4.
- HALT (only with the optional feature):
  - PcValid=0, Pc frozen, Trap=1.
  - All inputs are ignored; only reset exits.

Target selection
- Redirect select priority: JumpReg > Jump > BranchTaken.
- Target for JumpReg is AluResult & ~1; for Jump and BranchTaken it is AluResult.

Timing and arithmetic
- Latency: a redirect sampled at edge N is visible on Pc after edge N, i.e. one cycle.
- Wrap-around: Pc=32'hFFFF_FFFC sequences to 32'h0000_0000; no flag is raised.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined:
  - A target with bits [1:0] != 0, at the point it would be loaded into Pc, moves the state to HALT.
  - TrapPc = that target, Trap = 1; Pc keeps its last aligned value.
  - A misaligned target that is only captured into pending does not trap until it is applied.
- Undefined:
  - Target bits [1:0] are forced to 00.
  - Trap and TrapPc are tied to 0.
  - HALT is unreachable.

Decomposition:
- Package pc_unit_pkg contains:
  - state enum pc_state_t {BOOT, RUN, HALT}
  - localparam INSTR_BYTES = 4
  - redirect-select enum {RED_NONE, RED_BRANCH, RED_JAL, RED_JALR}
- Sub-module pc_target_sel (combinational):
  - Inputs: redirect flags and AluResult.
  - Outputs: redirect valid, aligned/forced target, misaligned flag.
- pc_unit contains the state register, the Pc register and the pending-redirect buffer.

Test Plan:
1. Reset, then release rst_n with RESET_VECTOR=0 and no stalls -> PcValid=0 for 1 cycle, then Pc sequences 0, 4, 8, 12.
2. At Pc=8, pulse Jump with AluResult=32'h100 -> next Pc=32'h100, then 32'h104. Pulse JumpReg with AluResult=32'h201 -> Pc=32'h200.
3. Stall=1 for 3 cycles; in the first stalled cycle pulse BranchTaken with AluResult=32'h40 -> Pc holds. First cycle with Stall=0 gives Pc=32'h40.
4. Force Pc to 32'hFFFF_FFFC via a redirect, no stall -> PcPlus4=0; next Pc=0.
5. With PC_MISALIGN_TRAP_EN, Jump with AluResult=32'h102 -> Trap=1, TrapPc=32'h102, PcValid=0, Pc frozen. Without the macro -> Pc=32'h100, Trap=0.
6. Assert rst_n=0 mid-stall with a pending redirect -> outputs reset immediately, without waiting for a clock edge. After release, Pc starts at RESET_VECTOR and the pending redirect is discarded.
